// File: rtl/wb_stage.sv
// Writeback stage: aligns load data, drives the register-file write port, and keeps
// the retire counters, a one-cycle decode bypass entry and a sticky misaligned-load trap.
package wb_stage_pkg;
  typedef struct packed {
    logic       load_regfile;
    logic [1:0] regfilemux_sel;
    logic [2:0] load_type;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] br;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } stage_regs;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_BR   = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;
endpackage

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  stage_regs        regs_in,
  input  logic [31:0]      dcache_out,
  input  logic             advance,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wdata,
  output logic             byp_valid,
  output logic [4:0]       byp_rd,
  output logic [31:0]      byp_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             trap,
  output logic [31:0]      trap_pc
);

  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic        misaligned;
  logic        retire;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    off    = regs_in.alu[1:0];
    byte_v = dcache_out[7:0];
    case (off)
      2'd1:    byte_v = dcache_out[15:8];
      2'd2:    byte_v = dcache_out[23:16];
      2'd3:    byte_v = dcache_out[31:24];
      default: byte_v = dcache_out[7:0];
    endcase
    half_v = off[1] ? dcache_out[31:16] : dcache_out[15:0];

    load_data  = dcache_out;
    misaligned = 1'b0;
    case (regs_in.ctrl.load_type)
      LT_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      LT_LBU: load_data = {24'd0, byte_v};
      LT_LH: begin
        load_data  = {{16{half_v[15]}}, half_v};
        misaligned = off[0];
      end
      LT_LHU: begin
        load_data  = {16'd0, half_v};
        misaligned = off[0];
      end
      LT_LW: misaligned = (off != 2'd0);
      default: misaligned = 1'b1;
    endcase
    // Only loads can trap; other mux selections never touch the cache word.
    if (regs_in.ctrl.regfilemux_sel != SEL_LOAD) misaligned = 1'b0;

    rf_wdata = regs_in.alu;
    case (regs_in.ctrl.regfilemux_sel)
      SEL_BR:   rf_wdata = regs_in.br;
      SEL_PC4:  rf_wdata = regs_in.pc + 32'd4;
      SEL_LOAD: rf_wdata = load_data;
      default:  rf_wdata = regs_in.alu;
    endcase

    retire = advance & regs_in.valid;
    rf_rd  = regs_in.rd;
    rf_we  = ~reset & retire & regs_in.ctrl.load_regfile & (regs_in.rd != 5'd0) & ~misaligned;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_valid   <= 1'b0;
      byp_rd      <= 5'd0;
      byp_data    <= 32'd0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      trap        <= 1'b0;
      trap_pc     <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;

      // A bypass entry lives for exactly one advancing cycle; stalls hold it.
      if (rf_we) begin
        byp_valid <= 1'b1;
        byp_rd    <= rf_rd;
        byp_data  <= rf_wdata;
      end else if (advance) begin
        byp_valid <= 1'b0;
      end

      if (retire && misaligned && !trap) begin
        trap    <= 1'b1;
        trap_pc <= regs_in.pc;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the write-value paths plus hand
// sequences for stalls, traps, reset and counter wrap.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  stage_regs   regs_in;
  logic [31:0] dcache_out;
  logic        advance;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic        trap;
  logic [31:0] trap_pc;

  stage_regs   idle_regs;
  logic        s_we, s_bv, s_trap;
  logic [4:0]  s_rd, s_brd;
  logic [31:0] s_wdata, s_bdata, s_tpc;
  logic [3:0]  s_cycle, s_instret;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .reset(reset), .regs_in(regs_in), .dcache_out(dcache_out),
    .advance(advance), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .trap(trap), .trap_pc(trap_pc)
  );

  // Narrow-counter instance so the wrap is reachable in a handful of cycles.
  wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .regs_in(idle_regs), .dcache_out(32'd0),
    .advance(1'b1), .rf_we(s_we), .rf_rd(s_rd), .rf_wdata(s_wdata),
    .byp_valid(s_bv), .byp_rd(s_brd), .byp_data(s_bdata),
    .cycle_cnt(s_cycle), .instret_cnt(s_instret), .trap(s_trap), .trap_pc(s_tpc)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_cycle;
  logic [63:0] exp_instret;

  typedef struct {
    string       name;
    logic [31:0] pc, alu, br;
    logic [4:0]  rd;
    logic        lr;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [31:0] dc;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] br, input logic [4:0] rd, input logic lr,
                       input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] dc,
                       input logic adv);
    regs_in.valid               = v;
    regs_in.pc                  = pc;
    regs_in.alu                 = alu;
    regs_in.br                  = br;
    regs_in.rd                  = rd;
    regs_in.ctrl.load_regfile   = lr;
    regs_in.ctrl.regfilemux_sel = sel;
    regs_in.ctrl.load_type      = lt;
    dcache_out                  = dc;
    advance                     = adv;
    #1;
  endtask

  task automatic drive_idle(input logic adv);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, adv);
  endtask

  // One clock: the reference counters follow the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      exp_cycle++;
      if (advance && regs_in.valid) exp_instret++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_regs = '0;
    vecs = '{
      '{"alu",       32'h100, 32'hDEADBEEF, 32'h0, 5'd3, 1'b1, 2'd0, 3'b000, 32'h0,         1'b1, 32'hDEADBEEF},
      '{"br",        32'h104, 32'h0,        32'h1, 5'd4, 1'b1, 2'd1, 3'b000, 32'h0,         1'b1, 32'h00000001},
      '{"lb_off3",   32'h108, 32'h1003,     32'h0, 5'd6, 1'b1, 2'd3, 3'b000, 32'h80FF0000,  1'b1, 32'hFFFFFF80},
      '{"lbu_off3",  32'h10C, 32'h1003,     32'h0, 5'd6, 1'b1, 2'd3, 3'b100, 32'h80FF0000,  1'b1, 32'h00000080},
      '{"lhu_off2",  32'h110, 32'h1002,     32'h0, 5'd7, 1'b1, 2'd3, 3'b101, 32'h80FF0000,  1'b1, 32'h000080FF},
      '{"lh_off2",   32'h114, 32'h1002,     32'h0, 5'd7, 1'b1, 2'd3, 3'b001, 32'h80FF0000,  1'b1, 32'hFFFF80FF},
      '{"lb_off0",   32'h118, 32'h2000,     32'h0, 5'd8, 1'b1, 2'd3, 3'b000, 32'h1234567F,  1'b1, 32'h0000007F},
      '{"lbu_off1",  32'h11C, 32'h2001,     32'h0, 5'd8, 1'b1, 2'd3, 3'b100, 32'h12345678,  1'b1, 32'h00000056},
      '{"lh_off0",   32'h120, 32'h2000,     32'h0, 5'd9, 1'b1, 2'd3, 3'b001, 32'h00008001,  1'b1, 32'hFFFF8001},
      '{"lw_off0",   32'h124, 32'h2004,     32'h0, 5'd9, 1'b1, 2'd3, 3'b010, 32'hCAFEF00D,  1'b1, 32'hCAFEF00D},
      '{"jal_pc4",   32'h100, 32'h0,        32'h0, 5'd1, 1'b1, 2'd2, 3'b000, 32'h0,         1'b1, 32'h00000104},
      '{"no_lr",     32'h128, 32'h55,       32'h0, 5'd7, 1'b0, 2'd0, 3'b000, 32'h0,         1'b0, 32'h00000055}
    };

    // Power-up reset, then run a few cycles so the counters are nonzero.
    reset = 1'b1;
    drive_idle(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cycle = '0;
    exp_instret = '0;
    repeat (5) tick();
    check("cycle_pre_reset", cycle_cnt, exp_cycle);

    // Reset arriving with a write pending clears everything and blocks the write.
    drive(1'b1, 32'h300, 32'h77, 32'h0, 5'd9, 1'b1, 2'd0, 3'd0, 32'h0, 1'b1);
    reset = 1'b1;
    #1;
    exp_cycle = '0;
    exp_instret = '0;
    check("reset_rf_we", rf_we, 0);
    check("reset_cycle", cycle_cnt, 0);
    check("reset_instret", instret_cnt, 0);
    check("reset_byp_valid", byp_valid, 0);
    check("reset_trap", trap, 0);
    @(negedge clk);
    drive_idle(1'b1);
    reset = 1'b0;
    tick();
    check("first_cycle", cycle_cnt, 1);
    check("first_instret", instret_cnt, 0);
    check("first_byp_data", byp_data, 0);
    check("first_trap_pc", trap_pc, 0);

    // Table: one retiring instruction per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].alu, vecs[i].br, vecs[i].rd, vecs[i].lr,
            vecs[i].sel, vecs[i].lt, vecs[i].dc, 1'b1);
      check({vecs[i].name, "_we"}, rf_we, vecs[i].exp_we);
      check({vecs[i].name, "_wdata"}, rf_wdata, vecs[i].exp_wdata);
      check({vecs[i].name, "_rd"}, rf_rd, vecs[i].rd);
      tick();
      check({vecs[i].name, "_byp_valid"}, byp_valid, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check({vecs[i].name, "_byp_rd"}, byp_rd, vecs[i].rd);
        check({vecs[i].name, "_byp_data"}, byp_data, vecs[i].exp_wdata);
      end
      check({vecs[i].name, "_instret"}, instret_cnt, exp_instret);
      check({vecs[i].name, "_trap"}, trap, 0);
    end

    // Stalled ALU op retires only once advance rises.
    drive(1'b1, 32'h200, 32'h1234, 32'h0, 5'd5, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_rf_we", rf_we, 0);
      tick();
      check("stall_instret", instret_cnt, exp_instret);
    end
    advance = 1'b1;
    #1;
    check("adv_rf_we", rf_we, 1);
    check("adv_wdata", rf_wdata, 32'h1234);
    tick();
    check("adv_instret", instret_cnt, exp_instret);
    check("adv_byp_valid", byp_valid, 1);
    check("adv_byp_rd", byp_rd, 5);
    check("adv_byp_data", byp_data, 32'h1234);
    drive_idle(1'b0);
    repeat (2) tick();
    check("byp_hold_stall", byp_valid, 1);
    drive_idle(1'b1);
    tick();
    check("byp_drop_adv", byp_valid, 0);

    // Misaligned loads: first one latches trap_pc, later ones do not move it.
    drive(1'b1, 32'h40, 32'h1002, 32'h0, 5'd8, 1'b1, 2'd3, 3'b010, 32'hAAAA5555, 1'b1);
    check("mis_lw_we", rf_we, 0);
    tick();
    check("mis_lw_trap", trap, 1);
    check("mis_lw_trap_pc", trap_pc, 32'h40);
    check("mis_lw_instret", instret_cnt, exp_instret);
    drive(1'b1, 32'h80, 32'h1001, 32'h0, 5'd8, 1'b1, 2'd3, 3'b101, 32'hAAAA5555, 1'b1);
    check("mis_lhu_we", rf_we, 0);
    tick();
    check("mis_lhu_trap_pc", trap_pc, 32'h40);
    drive(1'b1, 32'hC0, 32'h1000, 32'h0, 5'd8, 1'b1, 2'd3, 3'b011, 32'hAAAA5555, 1'b1);
    check("mis_undef_we", rf_we, 0);
    tick();
    check("mis_undef_trap", trap, 1);
    check("mis_undef_instret", instret_cnt, exp_instret);

    // x0 write suppressed; pc+4 wraps at 2^32.
    drive(1'b1, 32'h140, 32'h99, 32'h0, 5'd0, 1'b1, 2'd0, 3'd0, 32'h0, 1'b1);
    check("x0_we", rf_we, 0);
    tick();
    check("x0_byp_valid", byp_valid, 0);
    check("x0_instret", instret_cnt, exp_instret);
    drive(1'b1, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd1, 1'b1, 2'd2, 3'd0, 32'h0, 1'b1);
    check("jal_wrap_we", rf_we, 1);
    check("jal_wrap_wdata", rf_wdata, 32'h0);
    tick();

    // Reset mid-stall clears the sticky trap too.
    drive(1'b1, 32'h500, 32'h1, 32'h0, 5'd2, 1'b1, 2'd0, 3'd0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    exp_cycle = '0;
    exp_instret = '0;
    check("reset2_trap", trap, 0);
    check("reset2_trap_pc", trap_pc, 0);
    check("reset2_byp_valid", byp_valid, 0);
    @(negedge clk);
    drive_idle(1'b1);
    reset = 1'b0;

    // Counter wrap on the narrow instance, nothing else moves.
    repeat (15) tick();
    check("small_cycle_max", s_cycle, 4'hF);
    check("main_cycle_15", cycle_cnt, exp_cycle);
    tick();
    check("small_cycle_wrap", s_cycle, 4'h0);
    check("small_instret", s_instret, 0);
    check("small_byp_valid", s_bv, 0);
    check("small_trap", s_trap, 0);
    check("main_cycle_16", cycle_cnt, exp_cycle);
    check("main_instret_end", instret_cnt, exp_instret);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
